pe_chain_sequencer: RTL
=======================

Name: pe_chain_sequencer

Overview:
- Drives the head of the PE configuration daisy-chain, i.e. the config input of the first PE.
- Accepts instruction words for each PE over a valid/ready stream and emits one chain word per beat.
- After the last word, waits for the chain to drain, swaps the imem banks, arms, and issues a start pulse on run request.
- Times the run and signals completion. Sits between the host/DMA programming port and the PE array.

Parameters:
- INST_WIDTH, 64, instruction word width.
- ID, 2, width of the PE id field; the id decrements per PE hop.
- NUM_PE, 4, PEs in the chain; must be ≤ 2**ID.
- INST_WORD, 32, imem depth per PE.
- RUN_CYCLES, 32, cycles from start pulse to done.
- CONF, INST_WIDTH+ID+4, chain word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- prog_valid  in  1  instruction beat valid
- prog_ready  out  1  sequencer accepts beat
- prog_inst  in  INST_WIDTH  instruction word
- prog_pe  in  ID  target PE index (0 = first PE in chain)
- prog_last  in  1  final beat of the program
- run_req  in  1  request execution (level, sampled in ARM)
- busy  out  1  state != IDLE
- armed  out  1  state == ARM
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: dropped beat
- cfg_o  out  CONF  chain word {inst, id, valid, w_switch, r_switch, start}, MSB first

Behaviour:
Interface:
- One clock domain: clk.
- Reset is asynchronous and active-low (rst_n).
- On reset, all outputs are 0 except prog_ready = 1, state = IDLE, and all counters = 0.
- cfg_o is registered and all-zero on every cycle not listed below.

States:
- IDLE
  - prog_ready = 1.
  - An accepted beat is processed as in LOAD and moves to LOAD. If it also has prog_last, go directly to DRAIN.
- LOAD
  - prog_ready = 1.
  - Each handshake (prog_valid & prog_ready) drives cfg_o in the next cycle with inst = prog_inst, id = prog_pe, valid = 1, and switch/start = 0. Latency is 1 cycle; back-to-back beats are allowed.
  - Accepting a beat with prog_last goes to DRAIN and loads the drain counter with NUM_PE.
- DRAIN
  - prog_ready = 0.
  - The counter decrements each cycle; at 0, go to SWAP.
  - This guarantees the last word has passed every PE.
- SWAP
  - One cycle; prog_ready = 0.
  - cfg_o next cycle: w_switch = 1, r_switch = 1, valid = 0, inst = 0, id = 0. This word is broadcast as it ripples through the chain.
  - All per-PE word counters are cleared. Go to ARM.
- ARM
  - prog_ready = 0. Wait for run_req.
  - When run_req = 1, cfg_o next cycle has start = 1 and all other fields 0. Load the run counter with RUN_CYCLES + NUM_PE - 1 and go to RUN.
- RUN
  - prog_ready = 0.
  - The counter decrements; at 0, done = 1 for exactly one cycle and the state returns to IDLE.
  - prog_ready returns to 1 in the IDLE cycle.

Per-PE word counters (NUM_PE × ($clog2(INST_WORD)+1) bits):
- The counter for prog_pe increments on each accepted beat.
- If a beat targets prog_pe ≥ NUM_PE, or a PE whose count == INST_WORD:
  - The beat is still handshaked (prog_ready stays 1).
  - cfg_o stays zero for that beat.
  - err is set.
  - prog_last on a dropped beat still ends LOAD.
- err clears only on reset.

Boundary cases:
- run_req outside ARM is ignored.
- prog_valid while prog_ready = 0 stalls; no beat is lost.
- Reset mid-operation aborts immediately: cfg_o = 0 and state = IDLE. No switch or start is emitted.
- busy is 1 in every state except IDLE; armed = 1 only in ARM.

Test Plan:
1. Program 3 beats (pe 0, 1, 3; inst 0xA, 0xB, 0xC; last on the 3rd) → cfg_o shows 3 consecutive valid words with ids 0, 1, 3, each one cycle after its handshake. After exactly NUM_PE = 4 drain cycles, one SWAP word (w_switch = r_switch = 1). Then armed = 1.
2. From ARM, hold run_req low for 10 cycles, then raise it → no start until run_req. Then one cycle with start = 1 on cfg_o. done pulses exactly 35 cycles later (RUN_CYCLES + NUM_PE - 1 = 35). busy falls with return to IDLE.
3. Send 33 beats to pe 2 (last on the 33rd) → 32 valid cfg_o words, the 33rd dropped, err = 1 and stays 1 through SWAP/RUN. The next program accepts 32 words for pe 2 again (counters cleared by SWAP).
4. Single beat with prog_last in IDLE → goes directly to DRAIN. prog_ready = 0 during DRAIN/SWAP/ARM/RUN; a pending prog_valid is held and accepted only after done.
5. Assert rst_n = 0 during DRAIN (and separately during RUN) → cfg_o = 0, busy = 0, prog_ready = 1, err = 0 while in reset. No switch or start word is ever emitted afterwards without a new program.
6. run_req held high in LOAD → ignored. With run_req still high on entering ARM, start is issued on the first ARM cycle +1.

Source files
------------

// File: rtl/pe_chain_sequencer.sv
// Head-of-chain sequencer for the PE configuration daisy-chain: streams
// per-PE instruction words, drains, swaps imem banks, starts and times a run.
module pe_chain_sequencer #(
    parameter int INST_WIDTH = 64,
    parameter int ID         = 2,
    parameter int NUM_PE     = 4,
    parameter int INST_WORD  = 32,
    parameter int RUN_CYCLES = 32,
    parameter int CONF       = INST_WIDTH + ID + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_valid,
    output logic                  prog_ready,
    input  logic [INST_WIDTH-1:0] prog_inst,
    input  logic [ID-1:0]         prog_pe,
    input  logic                  prog_last,
    input  logic                  run_req,
    output logic                  busy,
    output logic                  armed,
    output logic                  done,
    output logic                  err,
    output logic [CONF-1:0]       cfg_o,
    output logic [2:0]            dbg_state_o
);

    localparam int PCW = $clog2(INST_WORD) + 1;
    localparam int CW  = $clog2(RUN_CYCLES + NUM_PE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_SWAP  = 3'd3,
        S_ARM   = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CONF-1:0] cfg_q, cfg_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [PCW-1:0]  pe_cnt_q [NUM_PE];
    logic [PCW-1:0]  pe_cnt_d [NUM_PE];
    logic            hs;
    logic            pe_ok;

    // A beat transfers on any cycle where prog_valid and prog_ready are both
    // high; prog_ready depends only on state, so a held beat waits without loss.
    assign prog_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign hs         = prog_valid && prog_ready;
    assign pe_ok      = (int'(prog_pe) < NUM_PE) && (pe_cnt_q[prog_pe] != PCW'(INST_WORD));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_d    = '0;
        done_d   = 1'b0;
        err_d    = err_q;
        pe_cnt_d = pe_cnt_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (hs) begin
                    if (pe_ok) begin
                        cfg_d             = {prog_inst, prog_pe, 4'b1000};
                        pe_cnt_d[prog_pe] = pe_cnt_q[prog_pe] + PCW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_LOAD;
                    if (prog_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = CW'(NUM_PE);
                    end
                end
            end
            // One cycle per PE hop so the last word has passed the tail.
            S_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_SWAP;
            end
            S_SWAP: begin
                cfg_d = CONF'(4'b0110);
                for (int i = 0; i < NUM_PE; i++) pe_cnt_d[i] = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (run_req) begin
                    cfg_d   = CONF'(1);
                    cnt_d   = CW'(RUN_CYCLES + NUM_PE - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) pe_cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            done_q   <= done_d;
            err_q    <= err_d;
            pe_cnt_q <= pe_cnt_d;
        end
    end

    assign cfg_o       = cfg_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = (state_q != S_IDLE);
    assign armed       = (state_q == S_ARM);
    assign dbg_state_o = state_q;

endmodule
